// File: rtl/mas_alu_pkg.sv
// Shared constants and enumerations for the MAS core ALU.
// Consumed by mas_alu_fsm and mas_alu_top (optional MAS_ALU_STATUS_EN status output lives in the top).
package mas_alu_pkg;

  localparam int unsigned MAS_BLEN = 32;
  localparam int unsigned MAS_SHW  = $clog2(MAS_BLEN);

  typedef enum logic [1:0] {
    MAS_ALU_ADD = 2'd0,
    MAS_ALU_SUB = 2'd1,
    MAS_ALU_SLL = 2'd2,
    MAS_ALU_SRL = 2'd3
  } type_mas_alu_cmd;

  typedef enum logic [1:0] {
    MAS_FSM_IDLE  = 2'd0,
    MAS_FSM_READY = 2'd1,
    MAS_FSM_OPER  = 2'd2,
    MAS_FSM_DONE  = 2'd3
  } type_mas_alu_fsm_state;

endpackage

// File: rtl/mas_alu_fsm.sv
// Control FSM for the MAS ALU: IDLE -> READY (capture) -> OPER (compute) -> DONE (present).
// Phase flags are registered alongside the state so they decode without glitches.
module mas_alu_fsm
  import mas_alu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mas_alu_req,
  output logic mas_alu_fsm_ready,
  output logic mas_alu_fsm_oper,
  output logic mas_alu_fsm_done
);

  type_mas_alu_fsm_state mas_alu_fsm_state;
  type_mas_alu_fsm_state mas_alu_fsm_state_d;

  // State register; phase flags follow the next state so they match the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mas_alu_fsm_state <= MAS_FSM_IDLE;
      mas_alu_fsm_ready <= 1'b0;
      mas_alu_fsm_oper  <= 1'b0;
      mas_alu_fsm_done  <= 1'b0;
    end else begin
      mas_alu_fsm_state <= mas_alu_fsm_state_d;
      mas_alu_fsm_ready <= (mas_alu_fsm_state_d == MAS_FSM_READY);
      mas_alu_fsm_oper  <= (mas_alu_fsm_state_d == MAS_FSM_OPER);
      mas_alu_fsm_done  <= (mas_alu_fsm_state_d == MAS_FSM_DONE);
    end
  end

  // Next-state logic; once READY is entered the operation always runs to DONE.
  always_comb begin
    mas_alu_fsm_state_d = mas_alu_fsm_state;
    case (mas_alu_fsm_state)
      MAS_FSM_IDLE:  if (mas_alu_req) mas_alu_fsm_state_d = MAS_FSM_READY;
      MAS_FSM_READY: mas_alu_fsm_state_d = MAS_FSM_OPER;
      MAS_FSM_OPER:  mas_alu_fsm_state_d = MAS_FSM_DONE;
      MAS_FSM_DONE:  mas_alu_fsm_state_d = mas_alu_req ? MAS_FSM_READY : MAS_FSM_IDLE;
      default:       mas_alu_fsm_state_d = MAS_FSM_IDLE;
    endcase
  end

endmodule

// File: rtl/mas_alu_top.sv
// Multi-cycle 4-op ALU (add/sub/sll/srl) with req/ready handshake; one op per three cycles.
// Define MAS_ALU_STATUS_EN to add the mas_alu_ovf carry/borrow/shift-out status output.
module mas_alu_top
  import mas_alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                mas_alu_req,
  input  logic [1:0]          mas_alu_cmd,
  input  logic [MAS_BLEN-1:0] mas_alu_op1,
  input  logic [MAS_BLEN-1:0] mas_alu_op2,
  output logic [MAS_BLEN-1:0] mas_alu_res,
  output logic                mas_alu_ready
`ifdef MAS_ALU_STATUS_EN
  ,
  output logic                mas_alu_ovf
`endif
);

  logic fsm_ready;
  logic fsm_oper;
  logic fsm_done;

  type_mas_alu_cmd     cmd_q;
  logic [MAS_BLEN-1:0] op1_q;
  logic [MAS_BLEN-1:0] op2_q;
  logic [MAS_BLEN-1:0] res_q;
  logic [MAS_BLEN-1:0] res_d;
  logic                shift_big;
  logic [MAS_SHW-1:0]  sh_amt;

  mas_alu_fsm mfsm (
    .clk               (clk),
    .rst               (rst),
    .mas_alu_req       (mas_alu_req),
    .mas_alu_fsm_ready (fsm_ready),
    .mas_alu_fsm_oper  (fsm_oper),
    .mas_alu_fsm_done  (fsm_done)
  );

  // Operands are sampled only on the READY->OPER edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= MAS_ALU_ADD;
      op1_q <= '0;
      op2_q <= '0;
    end else if (fsm_ready) begin
      cmd_q <= type_mas_alu_cmd'(mas_alu_cmd);
      op1_q <= mas_alu_op1;
      op2_q <= mas_alu_op2;
    end
  end

  assign shift_big = (op2_q >= MAS_BLEN'(MAS_BLEN));
  assign sh_amt    = op2_q[MAS_SHW-1:0];

`ifdef MAS_ALU_STATUS_EN
  logic [MAS_BLEN:0]     add_w;
  logic [2*MAS_BLEN-1:0] sll_w;
  logic [2*MAS_BLEN-1:0] srl_w;
  logic                  ovf_d;
  logic                  ovf_q;

  // Double-width shifts expose the bits pushed out of the result window.
  always_comb begin
    add_w = {1'b0, op1_q} + {1'b0, op2_q};
    sll_w = {MAS_BLEN'(0), op1_q} << sh_amt;
    srl_w = {op1_q, MAS_BLEN'(0)} >> sh_amt;
    res_d = '0;
    ovf_d = 1'b0;
    case (cmd_q)
      MAS_ALU_ADD: begin
        res_d = add_w[MAS_BLEN-1:0];
        ovf_d = add_w[MAS_BLEN];
      end
      MAS_ALU_SUB: begin
        res_d = op1_q - op2_q;
        ovf_d = (op1_q < op2_q);
      end
      MAS_ALU_SLL: begin
        res_d = shift_big ? '0 : sll_w[MAS_BLEN-1:0];
        ovf_d = shift_big ? (|op1_q) : (|sll_w[2*MAS_BLEN-1:MAS_BLEN]);
      end
      MAS_ALU_SRL: begin
        res_d = shift_big ? '0 : srl_w[2*MAS_BLEN-1:MAS_BLEN];
        ovf_d = shift_big ? (|op1_q) : (|srl_w[MAS_BLEN-1:0]);
      end
      default: begin
        res_d = '0;
        ovf_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (fsm_oper) begin
      ovf_q <= ovf_d;
    end
  end

  assign mas_alu_ovf = ovf_q;
`else
  // Operation mux on the captured operands; carry and shifted-out bits are dropped.
  always_comb begin
    res_d = '0;
    case (cmd_q)
      MAS_ALU_ADD: res_d = op1_q + op2_q;
      MAS_ALU_SUB: res_d = op1_q - op2_q;
      MAS_ALU_SLL: res_d = shift_big ? '0 : (op1_q << sh_amt);
      MAS_ALU_SRL: res_d = shift_big ? '0 : (op1_q >> sh_amt);
      default:     res_d = '0;
    endcase
  end
`endif

  // Result holds until the next OPER->DONE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else if (fsm_oper) begin
      res_q <= res_d;
    end
  end

  assign mas_alu_res   = res_q;
  assign mas_alu_ready = fsm_done;

endmodule

// File: tb/tb_mas_alu_top.sv
// Self-checking bench for mas_alu_top: directed vector table plus hand-written sequences
// for state walk, capture timing, back-to-back throughput and mid-operation reset.
module tb_mas_alu_top;
  import mas_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [1:0]  cmd;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] res;
  logic        ready;
`ifdef MAS_ALU_STATUS_EN
  logic        ovf;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  mas_alu_top dut (
    .clk           (clk),
    .rst           (rst),
    .mas_alu_req   (req),
    .mas_alu_cmd   (cmd),
    .mas_alu_op1   (op1),
    .mas_alu_op2   (op2),
    .mas_alu_res   (res),
    .mas_alu_ready (ready)
`ifdef MAS_ALU_STATUS_EN
    ,
    .mas_alu_ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input type_mas_alu_fsm_state exp);
    check(name, 32'(dut.mfsm.mas_alu_fsm_state), 32'(exp));
  endtask

  // Waits at negedges until ready is seen or max cycles pass; n is the cycles waited.
  task automatic wait_ready(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready !== 1'b1 && n < max);
  endtask

  function automatic logic [31:0] model(input logic [1:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    case (c)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return (b >= 32) ? 32'd0 : (a << b);
      default: return (b >= 32) ? 32'd0 : (a >> b);
    endcase
  endfunction

  initial begin
    int n;
    int ready_seen;
    logic [31:0] exp_res;

    vecs[0]  = '{2'd0, 32'd5,          32'd7,   32'd12,         1'b0};
    vecs[1]  = '{2'd1, 32'd3,          32'd5,   32'hFFFF_FFFE,  1'b1};
    vecs[2]  = '{2'd0, 32'hFFFF_FFFF,  32'd1,   32'd0,          1'b1};
    vecs[3]  = '{2'd2, 32'd1,          32'd31,  32'h8000_0000,  1'b0};
    vecs[4]  = '{2'd3, 32'h8000_0000,  32'd31,  32'd1,          1'b0};
    vecs[5]  = '{2'd2, 32'd1,          32'd32,  32'd0,          1'b1};
    vecs[6]  = '{2'd3, 32'h1234_5678,  32'd0,   32'h1234_5678,  1'b0};
    vecs[7]  = '{2'd1, 32'd10,         32'd3,   32'd7,          1'b0};
    vecs[8]  = '{2'd2, 32'hF000_0001,  32'd4,   32'h0000_0010,  1'b1};
    vecs[9]  = '{2'd3, 32'h0000_000F,  32'd2,   32'd3,          1'b1};
    vecs[10] = '{2'd3, 32'hFFFF_FFFF,  32'd100, 32'd0,          1'b1};
    vecs[11] = '{2'd0, 32'h8000_0000,  32'h8000_0000, 32'd0,    1'b1};

    rst = 1'b1; req = 1'b0; cmd = 2'd0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    check("reset_res", res, 32'd0);
    check("reset_ready", 32'(ready), 32'd0);
    check_state("reset_state", MAS_FSM_IDLE);
    rst = 1'b0;
    @(negedge clk);

    // State walk for ADD 5+7.
    req = 1'b1; cmd = 2'd0; op1 = 32'd5; op2 = 32'd7;
    check_state("walk_idle", MAS_FSM_IDLE);
    @(negedge clk);
    check_state("walk_ready", MAS_FSM_READY);
    check("walk_ready_lo1", 32'(ready), 32'd0);
    @(negedge clk);
    check_state("walk_oper", MAS_FSM_OPER);
    check("walk_ready_lo2", 32'(ready), 32'd0);
    @(negedge clk);
    check_state("walk_done", MAS_FSM_DONE);
    check("walk_ready_hi", 32'(ready), 32'd1);
    check("walk_res", res, 32'd12);
    req = 1'b0;
    @(negedge clk);
    check_state("walk_park", MAS_FSM_IDLE);
    check("walk_ready_drop", 32'(ready), 32'd0);
    check("walk_res_hold", res, 32'd12);

    // Directed vector table, each started from IDLE.
    for (int i = 0; i < 12; i++) begin
      req = 1'b1; cmd = vecs[i].cmd; op1 = vecs[i].op1; op2 = vecs[i].op2;
      wait_ready(6, n);
      check($sformatf("vec%0d_latency", i), 32'(n), 32'd3);
      check($sformatf("vec%0d_res", i), res, vecs[i].res);
`ifdef MAS_ALU_STATUS_EN
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
`endif
      req = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_pulse", i), 32'(ready), 32'd0);
    end

    // Inputs changed during OPER (and req dropped) must not affect the result.
    req = 1'b1; cmd = 2'd0; op1 = 32'd100; op2 = 32'd200;
    @(negedge clk);
    @(negedge clk);
    check_state("cap_oper", MAS_FSM_OPER);
    req = 1'b0; cmd = 2'd1; op1 = 32'd1; op2 = 32'd1;
    wait_ready(4, n);
    check("cap_latency", 32'(n), 32'd1);
    check("cap_res", res, 32'd300);
    @(negedge clk);
    check_state("cap_park", MAS_FSM_IDLE);

    // Ten back-to-back operations with req held high.
    req = 1'b1; cmd = 2'd0; op1 = 32'hA5A5_0005; op2 = 32'd0;
    for (int i = 0; i < 10; i++) begin
      exp_res = model(cmd, op1, op2);
      wait_ready(6, n);
      check($sformatf("b2b%0d_gap", i), 32'(n), 32'd3);
      check($sformatf("b2b%0d_res", i), res, exp_res);
      if (i < 9) begin
        cmd = 2'((i + 1) % 4);
        op1 = 32'((i + 1) * 37 + 5) ^ 32'hA5A5_0000;
        op2 = (((i + 1) % 4) >= 2) ? 32'((i + 1) * 3) : 32'((i + 1) * 1001);
      end else begin
        req = 1'b0;
      end
    end
    @(negedge clk);
    check_state("b2b_park", MAS_FSM_IDLE);
    repeat (3) @(negedge clk);
    check_state("b2b_stay_idle", MAS_FSM_IDLE);
    check("b2b_ready_low", 32'(ready), 32'd0);

    // Reset during OPER aborts the operation with no ready pulse.
    req = 1'b1; cmd = 2'd0; op1 = 32'd9; op2 = 32'd9;
    @(negedge clk);
    @(negedge clk);
    check_state("rst_in_oper", MAS_FSM_OPER);
    rst = 1'b1;
    @(negedge clk);
    check_state("rst_state", MAS_FSM_IDLE);
    check("rst_res", res, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    rst = 1'b0; req = 1'b0;
    ready_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready === 1'b1) ready_seen++;
    end
    check("rst_no_done", 32'(ready_seen), 32'd0);
    check("rst_res_stays", res, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
